// File: rtl/change_dispenser.sv
// change_dispenser: pays out a set of note counts, largest denomination first, one note per hopper handshake.
// Define CHANGE_DISPENSER_INVENTORY_EN to add per-denomination stock, restock and shortfall tracking.
//
// state  | meaning
// IDLE   | waiting for load
// SELECT | choosing highest denomination still owed
// EJECT  | eject_valid held until the hopper accepts
// GAP    | EJECT_GAP quiet cycles between notes
// DONE   | one-cycle done pulse, then IDLE

module change_dispenser #(
  parameter int unsigned INIT_STOCK = 50,
  parameter int unsigned EJECT_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] notes_100,
  input  logic [31:0] notes_50,
  input  logic [31:0] notes_20,
  input  logic [31:0] notes_10,
  input  logic [31:0] notes_5,
  input  logic        restock,
  input  logic        eject_ready,
  output logic        eject_valid,
  output logic [2:0]  eject_denom,
  output logic        busy,
  output logic        done,
  output logic [31:0] paid_total,
  output logic [31:0] shortfall
);

  localparam int unsigned GW = (EJECT_GAP > 1) ? $clog2(EJECT_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (EJECT_GAP > 0) ? GW'(EJECT_GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE
  } state_e;

  // Denomination index 0..4 = 5,10,20,50,100; eject code is index+1.
  function automatic logic [31:0] note_value(input logic [2:0] idx);
    case (idx)
      3'd0:    note_value = 32'd5;
      3'd1:    note_value = 32'd10;
      3'd2:    note_value = 32'd20;
      3'd3:    note_value = 32'd50;
      3'd4:    note_value = 32'd100;
      default: note_value = 32'd0;
    endcase
  endfunction

  state_e        state_q;
  logic [31:0]   rem_q [5];
  logic [2:0]    cur_q;
  logic [GW-1:0] gap_q;
  logic          eject_valid_q;
  logic [2:0]    eject_denom_q;
  logic          busy_q;
  logic          done_q;
  logic [31:0]   paid_q;

`ifdef CHANGE_DISPENSER_INVENTORY_EN
  logic [7:0]    stock_q [5];
  logic [31:0]   short_q;
`else
  logic          unused_restock;
  assign unused_restock = restock;
`endif

  logic          any_d;
  logic [2:0]    top_d;

  always_comb begin
    any_d = 1'b0;
    top_d = '0;
    for (int i = 0; i < 5; i++) begin
      if (rem_q[i] != '0) begin
        any_d = 1'b1;
        top_d = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      gap_q         <= '0;
      eject_valid_q <= 1'b0;
      eject_denom_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      paid_q        <= '0;
      for (int i = 0; i < 5; i++) rem_q[i] <= '0;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
      short_q       <= '0;
      for (int i = 0; i < 5; i++) stock_q[i] <= 8'(INIT_STOCK);
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            rem_q[0] <= notes_5;
            rem_q[1] <= notes_10;
            rem_q[2] <= notes_20;
            rem_q[3] <= notes_50;
            rem_q[4] <= notes_100;
            paid_q   <= '0;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
            short_q  <= '0;
`endif
            busy_q   <= 1'b1;
            state_q  <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (!any_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
`ifdef CHANGE_DISPENSER_INVENTORY_EN
          // Out of this note: write off what is owed in it and re-pick next cycle.
          else if (stock_q[top_d] == '0) begin
            short_q       <= short_q + note_value(top_d) * rem_q[top_d];
            rem_q[top_d]  <= '0;
          end
`endif
          else begin
            cur_q         <= top_d;
            eject_valid_q <= 1'b1;
            eject_denom_q <= top_d + 3'd1;
            state_q       <= S_EJECT;
          end
        end

        S_EJECT: begin
          if (eject_ready) begin
            eject_valid_q <= 1'b0;
            eject_denom_q <= '0;
            paid_q        <= paid_q + note_value(cur_q);
            if (rem_q[cur_q] != '0) rem_q[cur_q] <= rem_q[cur_q] - 32'd1;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
            if (stock_q[cur_q] != '0) stock_q[cur_q] <= stock_q[cur_q] - 8'd1;
`endif
            if (EJECT_GAP == 0) begin
              state_q <= S_SELECT;
            end else begin
              gap_q   <= GAP_LOAD;
              state_q <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_q == '0) state_q <= S_SELECT;
          else             gap_q   <= gap_q - 1'b1;
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
`ifdef CHANGE_DISPENSER_INVENTORY_EN
      // Placed after the case so a coincident handshake decrement is overridden.
      if (restock) begin
        for (int i = 0; i < 5; i++) stock_q[i] <= 8'(INIT_STOCK);
      end
`endif
    end
  end

  assign eject_valid = eject_valid_q;
  assign eject_denom = eject_denom_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign paid_total  = paid_q;
`ifdef CHANGE_DISPENSER_INVENTORY_EN
  assign shortfall   = short_q;
`else
  assign shortfall   = '0;
`endif

endmodule
